// File: rtl/f3_pkg.sv
// f3_pkg: shared command codes, state encoding, grid geometry and LFSR mask for the f3 offset controller.
package f3_pkg;
   localparam int GRID_BITS = 4;
   localparam int GRID_SIZE = 16;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [3:0] F3_CMD_NOP      = 4'd0;
   localparam logic [3:0] F3_CMD_SCRAMBLE = 4'd1;
   localparam logic [3:0] F3_CMD_CLEAR    = 4'd2;
   localparam logic [3:0] F3_CMD_LEFT     = 4'd3;
   localparam logic [3:0] F3_CMD_RIGHT    = 4'd4;
   localparam logic [3:0] F3_CMD_UP       = 4'd5;
   localparam logic [3:0] F3_CMD_DOWN     = 4'd6;
   localparam logic [3:0] F3_CMD_ROT_COL  = 4'd7;
   localparam logic [3:0] F3_CMD_ROT_ROW  = 4'd8;
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
   typedef logic [GRID_SIZE-1:0][GRID_BITS-1:0] tbl_t;
endpackage

// File: rtl/f3_offset_ctrl_if.sv
// f3_offset_ctrl_if: valid/ready command channel from game logic to the offset controller.
interface f3_offset_ctrl_if;
   logic       cmd_valid;
   logic [3:0] cmd;
   logic       cmd_ready;
   modport master (output cmd_valid, output cmd, input cmd_ready);
   modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/f3_lfsr16.sv
// f3_lfsr16: free-running 16-bit Galois LFSR; exposes the low byte used to fill the offset tables.
module f3_lfsr16
   import f3_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic       sysclk,
   input  logic       reset_n,
   output logic [7:0] rnd
);
   logic [15:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_MASK);
   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) lfsr_q <= SEED;
      else          lfsr_q <= lfsr_d;
   assign rnd = lfsr_q[7:0];
endmodule

// File: rtl/f3_offset_ctrl.sv
// f3_offset_ctrl: edits working offset tables from game commands and commits them to the GPU-visible copy.
// Define F3_CURSOR_WRAP_EN for modulo-16 cursor wrap; otherwise the cursor saturates at the grid edges.
module f3_offset_ctrl
   import f3_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED        = 16'hACE1,
   parameter bit          COMMIT_ON_VBLANK = 1'b1
) (
   input  logic                  sysclk,
   input  logic                  reset_n,
   f3_offset_ctrl_if.slave       cmd_if,
   input  logic                  vblank,
   input  logic [GRID_BITS-1:0]  lookup_x,
   input  logic [GRID_BITS-1:0]  lookup_y,
   output logic [GRID_BITS-1:0]  x_offset,
   output logic [GRID_BITS-1:0]  y_offset,
   output logic [GRID_BITS-1:0]  cursor_x,
   output logic [GRID_BITS-1:0]  cursor_y,
   output logic                  busy,
   output logic                  solved
);
   state_t     state_q, state_d;
   tbl_t       wx_q, wx_d, wy_q, wy_d, ax_q, ax_d, ay_q, ay_d;
   logic [3:0] cx_q, cx_d, cy_q, cy_d, idx_q, idx_d;
   logic       dirty_q, dirty_d, solved_q, solved_d, vblank_q;
   logic [7:0] rnd;
   logic       acc, edit, fill_done, commit;

   function automatic logic [3:0] mv(input logic [3:0] v, input logic inc);
`ifdef F3_CURSOR_WRAP_EN
      return inc ? v + 4'd1 : v - 4'd1;
`else
      return inc ? (v == 4'd15 ? v : v + 4'd1) : (v == 4'd0 ? v : v - 4'd1);
`endif
   endfunction

   f3_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.sysclk(sysclk), .reset_n(reset_n), .rnd(rnd));

   assign acc       = cmd_if.cmd_valid & cmd_if.cmd_ready;
   assign fill_done = (state_q == FILL) & (idx_q == 4'd15);
   // A running fill holds off the commit so a half-scrambled table never goes live.
   assign commit    = dirty_q & (state_q == IDLE) & (COMMIT_ON_VBLANK ? (vblank & ~vblank_q) : 1'b1);

   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;

   always_comb
      state_d = (state_q == IDLE) ? ((acc && cmd_if.cmd == F3_CMD_SCRAMBLE) ? FILL : IDLE)
                                  : (fill_done ? IDLE : FILL);

   always_comb begin
      cmd_if.cmd_ready = (state_q == IDLE);
      busy             = (state_q == FILL) | dirty_q;
   end

   always_comb begin
      wx_d  = wx_q;
      wy_d  = wy_q;
      ax_d  = ax_q;
      ay_d  = ay_q;
      cx_d  = cx_q;
      cy_d  = cy_q;
      idx_d = idx_q;
      edit  = 1'b0;
      if (commit) begin
         ax_d = wx_q;
         ay_d = wy_q;
      end
      if (state_q == FILL) begin
         wx_d[idx_q] = rnd[3:0];
         wy_d[idx_q] = rnd[7:4];
         idx_d       = idx_q + 4'd1;
      end else if (acc) begin
         case (cmd_if.cmd)
            F3_CMD_SCRAMBLE: idx_d = 4'd0;
            F3_CMD_CLEAR:    begin wx_d = '0; wy_d = '0; edit = 1'b1; end
            F3_CMD_LEFT:     cx_d = mv(cx_q, 1'b0);
            F3_CMD_RIGHT:    cx_d = mv(cx_q, 1'b1);
            F3_CMD_UP:       cy_d = mv(cy_q, 1'b0);
            F3_CMD_DOWN:     cy_d = mv(cy_q, 1'b1);
            F3_CMD_ROT_COL:  begin wx_d[cx_q] = wx_q[cx_q] + 4'd1; edit = 1'b1; end
            F3_CMD_ROT_ROW:  begin wy_d[cy_q] = wy_q[cy_q] + 4'd1; edit = 1'b1; end
            default:         ;
         endcase
      end
      dirty_d  = edit | fill_done | (dirty_q & ~commit);
      solved_d = (ax_q == '0) & (ay_q == '0);
   end

   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) begin
         wx_q     <= '0;
         wy_q     <= '0;
         ax_q     <= '0;
         ay_q     <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         idx_q    <= '0;
         dirty_q  <= 1'b0;
         solved_q <= 1'b1;
         vblank_q <= 1'b0;
      end else begin
         wx_q     <= wx_d;
         wy_q     <= wy_d;
         ax_q     <= ax_d;
         ay_q     <= ay_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         idx_q    <= idx_d;
         dirty_q  <= dirty_d;
         solved_q <= solved_d;
         vblank_q <= vblank;
      end

   assign x_offset = ax_q[lookup_x];
   assign y_offset = ay_q[lookup_y];
   assign cursor_x = cx_q;
   assign cursor_y = cy_q;
   assign solved   = solved_q;
endmodule

// File: tb/tb_f3_offset_ctrl.sv
// tb_f3_offset_ctrl: directed self-checking bench for f3_offset_ctrl with a reference LFSR model.
module tb_f3_offset_ctrl;
   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic       vblank = 1'b0;
   logic [3:0] lookup_x = 4'd0, lookup_y = 4'd0;
   logic [3:0] x_offset, y_offset, cursor_x, cursor_y;
   logic       busy, solved;
   int         n_chk = 0, n_fail = 0;
   logic [15:0] ref_q;
   logic [3:0] act_x [16], act_y [16], exp_x [16], exp_y [16];
`ifdef F3_CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   f3_offset_ctrl_if cmd_if ();

   f3_offset_ctrl dut (
      .sysclk(sysclk), .reset_n(reset_n), .cmd_if(cmd_if), .vblank(vblank),
      .lookup_x(lookup_x), .lookup_y(lookup_y), .x_offset(x_offset), .y_offset(y_offset),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy), .solved(solved)
   );

   always #50 sysclk = ~sysclk;

   always @(posedge sysclk or negedge reset_n)
      if (!reset_n) ref_q <= 16'hACE1;
      else          ref_q <= {1'b0, ref_q[15:1]} ^ (ref_q[0] ? 16'hB400 : 16'h0000);

   task automatic tick;
      @(posedge sysclk);
      #1;
   endtask

   task automatic send(input logic [3:0] c);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd = c;
      tick();
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd = 4'd0;
   endtask

   task automatic pulse_vblank;
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
   endtask

   task automatic test_reset;
      logic [3:0] got [7], want [7];
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin act_x[i] = 4'd0; act_y[i] = 4'd0; end
      lookup_x = 4'd5;
      lookup_y = 4'd9;
      #1;
      got  = '{x_offset, y_offset, {3'b0, solved}, cursor_x, cursor_y, {3'b0, busy}, {3'b0, cmd_if.cmd_ready}};
      want = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
      for (int i = 0; i < 7; i++) begin
         n_chk++;
         if (got[i] !== want[i]) begin
            n_fail++;
            $display("FAIL reset item %0d got %0d want %0d", i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_cursor_rot;
      repeat (3) send(4'd4);
      repeat (2) send(4'd6);
      repeat (2) send(4'd7);
      lookup_x = 4'd3;
      #1;
      n_chk++;
      if (cursor_x !== 4'd3 || cursor_y !== 4'd2 || busy !== 1'b1 || x_offset !== 4'd0) begin
         n_fail++;
         $display("FAIL edit_pre_commit got cur=(%0d,%0d) busy=%0b x=%0d want cur=(3,2) busy=1 x=0", cursor_x, cursor_y, busy, x_offset);
      end
      pulse_vblank();
      act_x[3] = 4'd2;
      n_chk++;
      if (x_offset !== 4'd2 || solved !== 1'b1) begin
         n_fail++;
         $display("FAIL commit_edge got x=%0d solved=%0b want x=2 solved=1", x_offset, solved);
      end
      tick();
      n_chk++;
      if (solved !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_commit got solved=%0b busy=%0b want 0 0", solved, busy);
      end
   endtask

   task automatic test_scramble;
      int low = 0;
      logic all0 = 1'b1;
      send(4'd1);
      for (int k = 0; k < 16; k++) begin
         exp_x[k] = ref_q[3:0];
         exp_y[k] = ref_q[7:4];
         if (cmd_if.cmd_ready === 1'b0) low++;
         tick();
      end
      n_chk++;
      if (low != 16 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_len got low=%0d ready=%0b busy=%0b want 16 1 1", low, cmd_if.cmd_ready, busy);
      end
      for (int i = 0; i < 16; i++) begin
         lookup_x = 4'(i); lookup_y = 4'(i); #1;
         n_chk++;
         if (x_offset !== act_x[i] || y_offset !== act_y[i]) begin
            n_fail++;
            $display("FAIL scramble_hold[%0d] got x=%0d y=%0d want x=%0d y=%0d", i, x_offset, y_offset, act_x[i], act_y[i]);
         end
      end
      pulse_vblank();
      for (int i = 0; i < 16; i++) begin
         act_x[i] = exp_x[i]; act_y[i] = exp_y[i];
         if (exp_x[i] != 4'd0 || exp_y[i] != 4'd0) all0 = 1'b0;
         lookup_x = 4'(i); lookup_y = 4'(i); #1;
         n_chk++;
         if (x_offset !== exp_x[i] || y_offset !== exp_y[i]) begin
            n_fail++;
            $display("FAIL scramble_tbl[%0d] got x=%0d y=%0d want x=%0d y=%0d", i, x_offset, y_offset, exp_x[i], exp_y[i]);
         end
      end
      tick();
      n_chk++;
      if (solved !== all0) begin
         n_fail++;
         $display("FAIL scramble_solved got %0b want %0b", solved, all0);
      end
   endtask

   task automatic test_clear;
      send(4'd8);
      send(4'd1);
      for (int k = 0; k < 16; k++) begin
         vblank = (k == 4);
         tick();
      end
      vblank = 1'b0;
      n_chk++;
      if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_block_state got busy=%0b ready=%0b want 1 1", busy, cmd_if.cmd_ready);
      end
      for (int i = 0; i < 16; i++) begin
         lookup_x = 4'(i); lookup_y = 4'(i); #1;
         n_chk++;
         if (x_offset !== act_x[i] || y_offset !== act_y[i]) begin
            n_fail++;
            $display("FAIL fill_block[%0d] got x=%0d y=%0d want x=%0d y=%0d", i, x_offset, y_offset, act_x[i], act_y[i]);
         end
      end
      send(4'd2);
      pulse_vblank();
      for (int i = 0; i < 16; i++) begin
         act_x[i] = 4'd0; act_y[i] = 4'd0;
         lookup_x = 4'(i); lookup_y = 4'(i); #1;
         n_chk++;
         if (x_offset !== 4'd0 || y_offset !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_tbl[%0d] got x=%0d y=%0d want 0 0", i, x_offset, y_offset);
         end
      end
      tick();
      n_chk++;
      if (solved !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_solved got solved=%0b busy=%0b want 1 0", solved, busy);
      end
   endtask

   task automatic test_rot_row_wrap;
      repeat (2) send(4'd5);
      repeat (15) send(4'd8);
      pulse_vblank();
      lookup_y = 4'd0;
      #1;
      n_chk++;
      if (cursor_y !== 4'd0 || y_offset !== 4'd15) begin
         n_fail++;
         $display("FAIL rot_row15 got cy=%0d y=%0d want 0 15", cursor_y, y_offset);
      end
      tick();
      n_chk++;
      if (solved !== 1'b0) begin
         n_fail++;
         $display("FAIL rot_row15_solved got %0b want 0", solved);
      end
      send(4'd8);
      pulse_vblank();
      n_chk++;
      if (y_offset !== 4'd0) begin
         n_fail++;
         $display("FAIL rot_row_wrap got y=%0d want 0", y_offset);
      end
      tick();
      n_chk++;
      if (solved !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rot_row_wrap_solved got solved=%0b busy=%0b want 1 0", solved, busy);
      end
   endtask

   task automatic test_cursor_edge;
      logic [3:0] ex;
      repeat (3) send(4'd3);
      n_chk++;
      if (cursor_x !== 4'd0) begin
         n_fail++;
         $display("FAIL left_to_zero got %0d want 0", cursor_x);
      end
      send(4'd3);
      ex = WRAP ? 4'd15 : 4'd0;
      n_chk++;
      if (cursor_x !== ex) begin
         n_fail++;
         $display("FAIL left_edge got %0d want %0d", cursor_x, ex);
      end
      repeat (16) send(4'd4);
      n_chk++;
      if (cursor_x !== 4'd15) begin
         n_fail++;
         $display("FAIL right_run got %0d want 15", cursor_x);
      end
      send(4'd4);
      ex = WRAP ? 4'd0 : 4'd15;
      n_chk++;
      if (cursor_x !== ex) begin
         n_fail++;
         $display("FAIL right_edge got %0d want %0d", cursor_x, ex);
      end
      send(4'd5);
      n_chk++;
      if (cursor_y !== (WRAP ? 4'd15 : 4'd0)) begin
         n_fail++;
         $display("FAIL up_edge got %0d want %0d", cursor_y, WRAP ? 15 : 0);
      end
      send(4'd12);
      n_chk++;
      if (cursor_x !== ex || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ignored_cmd got cx=%0d busy=%0b ready=%0b want %0d 0 1", cursor_x, busy, cmd_if.cmd_ready, ex);
      end
   endtask

   task automatic test_reset_mid_fill;
      logic [3:0] cx;
      cx = WRAP ? 4'd0 : 4'd15;
      send(4'd7);
      pulse_vblank();
      lookup_x = cx;
      #1;
      n_chk++;
      if (x_offset !== 4'd1) begin
         n_fail++;
         $display("FAIL pre_reset_col got %0d want 1", x_offset);
      end
      send(4'd1);
      repeat (7) tick();
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || solved !== 1'b1 || cursor_x !== 4'd0 ||
          cursor_y !== 4'd0 || x_offset !== 4'd0 || y_offset !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_fill_reset got ready=%0b busy=%0b solved=%0b cur=(%0d,%0d) x=%0d y=%0d want 1 0 1 (0,0) 0 0",
                  cmd_if.cmd_ready, busy, solved, cursor_x, cursor_y, x_offset, y_offset);
      end
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      n_chk++;
      if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || x_offset !== 4'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle got ready=%0b busy=%0b x=%0d want 1 0 0", cmd_if.cmd_ready, busy, x_offset);
      end
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd = 4'd0;
      test_reset();
      test_cursor_rot();
      test_scramble();
      test_clear();
      test_rot_row_wrap();
      test_cursor_edge();
      test_reset_mid_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
